// File: rtl/flag_branch_evaluator_if.sv
// Flag-commit, branch-request and branch-response signals between the ALU flag
// stage, the flag/branch evaluator and the branch/fetch control logic.
interface flag_branch_evaluator_if;
    logic       flags_valid;
    logic [3:0] alu_sel;
    logic       carry_in;
    logic       neg_in;
    logic       equal_in;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_cond;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_taken;
    logic       rsp_err;
    logic [2:0] flags_q;

    modport master (
        output flags_valid, alu_sel, carry_in, neg_in, equal_in,
        output req_valid, req_cond, rsp_ready,
        input  req_ready, rsp_valid, rsp_taken, rsp_err, flags_q
    );

    modport slave (
        input  flags_valid, alu_sel, carry_in, neg_in, equal_in,
        input  req_valid, req_cond, rsp_ready,
        output req_ready, rsp_valid, rsp_taken, rsp_err, flags_q
    );
endinterface

// File: rtl/flag_branch_evaluator.sv
// Persistent {C,N,Z} status register with selective update, and a branch condition
// evaluator behind a valid/ready request channel with a one-entry response slot.
module flag_branch_evaluator #(
    parameter bit FWD = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    flag_branch_evaluator_if.slave        bus
);
    typedef enum logic {EMPTY, FULL} slot_t;

    slot_t       slot_reg;
    logic [2:0]  flags_reg;
    logic [2:0]  flags_next;
    logic [2:0]  eff;
    logic        taken_reg;
    logic        err_reg;
    logic [15:0] cond_table;
    logic        rsp_valid_int;
    logic        req_ready_int;
    logic        accept;
    logic        drain;

    // Only the flags the committed op defines are written; the rest are kept.
    always_comb begin
        flags_next = flags_reg;
        if (bus.flags_valid) begin
            case (bus.alu_sel)
                4'd0: flags_next[2] = bus.carry_in;
                4'd1: begin
                    flags_next[1] = bus.neg_in;
                    flags_next[0] = bus.equal_in;
                end
                default: ;
            endcase
        end
    end

    assign eff = (FWD && bus.flags_valid) ? flags_next : flags_reg;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [2:0] f);
        logic c, n, z;
        c = f[2];
        n = f[1];
        z = f[0];
        case (cond)
            4'd0:    return 1'b1;
            4'd1:    return z;
            4'd2:    return !z;
            4'd3:    return c;
            4'd4:    return !c;
            4'd5:    return n;
            4'd6:    return !n;
            4'd7:    return !z && !n;
            4'd8:    return z || n;
            default: return 1'b0;
        endcase
    endfunction

    for (genvar gi = 0; gi < 16; gi++) begin : g_cond
        assign cond_table[gi] = cond_eval(4'(gi), eff);
    end

    assign rsp_valid_int = (slot_reg == FULL);
    assign req_ready_int = !reset && (!rsp_valid_int || bus.rsp_ready)
                           && !(!FWD && bus.flags_valid);
    assign accept        = bus.req_valid && req_ready_int;
    assign drain         = rsp_valid_int && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_reg  <= EMPTY;
            flags_reg <= 3'b000;
            taken_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            flags_reg <= flags_next;
            case (slot_reg)
                EMPTY: begin
                    if (accept) begin
                        slot_reg  <= FULL;
                        taken_reg <= cond_table[bus.req_cond];
                        err_reg   <= (bus.req_cond >= 4'd10);
                    end
                end
                FULL: begin
                    // An accept while full implies a same-cycle drain (req_ready needs rsp_ready).
                    if (accept) begin
                        taken_reg <= cond_table[bus.req_cond];
                        err_reg   <= (bus.req_cond >= 4'd10);
                    end else if (drain) begin
                        slot_reg <= EMPTY;
                    end
                end
                default: slot_reg <= EMPTY;
            endcase
        end
    end

    assign bus.req_ready = req_ready_int;
    assign bus.rsp_valid = rsp_valid_int;
    assign bus.rsp_taken = taken_reg;
    assign bus.rsp_err   = err_reg;
    assign bus.flags_q   = flags_reg;
endmodule

// File: tb/tb_flag_branch_evaluator.sv
// Scoreboard bench for flag_branch_evaluator: a forwarding instance (a) and a
// non-forwarding instance (b) share clock and reset.
module tb_flag_branch_evaluator;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    typedef struct {
        logic taken;
        logic err;
        logic [3:0] cond;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       exp_b[$];
    exp_t       e;
    logic [2:0] m_flags;

    flag_branch_evaluator_if a ();
    flag_branch_evaluator_if b ();

    flag_branch_evaluator #(.FWD(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(a));
    flag_branch_evaluator #(.FWD(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] upd(input logic [2:0] f, input logic [3:0] sel,
                                       input logic c, input logic n, input logic z);
        logic [2:0] r;
        r = f;
        if (sel == 4'd0) r[2] = c;
        else if (sel == 4'd1) r[1:0] = {n, z};
        return r;
    endfunction

    function automatic exp_t model(input logic [3:0] cond, input logic [2:0] f);
        exp_t r;
        logic c, n, z;
        {c, n, z} = f;
        r.cond  = cond;
        r.err   = (cond > 4'd9);
        case (cond)
            4'd0: r.taken = 1'b1;
            4'd1: r.taken = z;
            4'd2: r.taken = ~z;
            4'd3: r.taken = c;
            4'd4: r.taken = ~c;
            4'd5: r.taken = n;
            4'd6: r.taken = ~n;
            4'd7: r.taken = ~(z | n);
            4'd8: r.taken = z | n;
            default: r.taken = 1'b0;
        endcase
        return r;
    endfunction

    task automatic idle_inputs();
        a.flags_valid = 0; a.alu_sel = 0; a.carry_in = 0; a.neg_in = 0; a.equal_in = 0;
        a.req_valid = 0; a.req_cond = 0; a.rsp_ready = 1;
        b.flags_valid = 0; b.alu_sel = 0; b.carry_in = 0; b.neg_in = 0; b.equal_in = 0;
        b.req_valid = 0; b.req_cond = 0; b.rsp_ready = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        a.req_valid = 1;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (a.req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b want=0", a.req_ready); end
            checks++; if (a.flags_q !== 3'b000) begin failures++; $display("FAIL reset_flags_q got=%b want=000", a.flags_q); end
            checks++; if (a.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", a.rsp_valid); end
        end
        m_flags = 3'b000;
        reset = 0;
        #1;
        checks++; if (a.req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_req_ready got=%b want=1", a.req_ready); end
        exp_q.push_back(model(4'd0, m_flags));
        @(negedge clk);
        a.req_valid = 0;
        checks++;
        if (a.rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            failures++; $display("FAIL post_reset_rsp rsp_valid got=%b want=1", a.rsp_valid);
        end else begin
            e = exp_q.pop_front();
            $display("rsp cond=%0d taken=%b err=%b", e.cond, a.rsp_taken, a.rsp_err);
            if ({a.rsp_taken, a.rsp_err} !== {e.taken, e.err}) begin
                failures++; $display("FAIL post_reset_rsp got=%b%b want=%b%b", a.rsp_taken, a.rsp_err, e.taken, e.err);
            end
        end
    endtask

    task automatic test_flags();
        logic [3:0] sel_t[4] = '{4'd0, 4'd1, 4'd5, 4'd0};
        logic [2:0] cnz_t[4] = '{3'b111, 3'b001, 3'b111, 3'b000};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (a.flags_q !== m_flags) begin failures++; $display("FAIL flags_step%0d got=%b want=%b", i, a.flags_q, m_flags); end
                else $display("flags step=%0d flags_q=%b", i, a.flags_q);
            end
            if (i < 4) begin
                a.flags_valid = 1; a.alu_sel = sel_t[i];
                {a.carry_in, a.neg_in, a.equal_in} = cnz_t[i];
                m_flags = upd(m_flags, sel_t[i], cnz_t[i][2], cnz_t[i][1], cnz_t[i][0]);
            end else begin
                a.flags_valid = 0;
            end
        end
    endtask

    task automatic test_sweep();
        @(negedge clk);
        a.flags_valid = 1; a.alu_sel = 4'd1; a.carry_in = 0; a.neg_in = 1; a.equal_in = 0;
        m_flags = upd(m_flags, 4'd1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        a.flags_valid = 0;
        checks++; if (a.flags_q !== 3'b010) begin failures++; $display("FAIL sweep_flags got=%b want=010", a.flags_q); end
        a.rsp_ready = 1;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                @(negedge clk);
                checks++;
                if (a.rsp_valid !== 1'b1 || exp_q.size() == 0) begin
                    failures++; $display("FAIL sweep_valid_%0d got=%b want=1", i - 1, a.rsp_valid);
                end else begin
                    e = exp_q.pop_front();
                    $display("rsp cond=%0d taken=%b err=%b", e.cond, a.rsp_taken, a.rsp_err);
                    if ({a.rsp_taken, a.rsp_err} !== {e.taken, e.err}) begin
                        failures++; $display("FAIL sweep_cond_%0d got=%b%b want=%b%b", e.cond, a.rsp_taken, a.rsp_err, e.taken, e.err);
                    end
                end
            end
            if (i < 16) begin
                a.req_valid = 1; a.req_cond = 4'(i);
                exp_q.push_back(model(4'(i), m_flags));
                #1;
                checks++; if (a.req_ready !== 1'b1) begin failures++; $display("FAIL sweep_ready_%0d got=%b want=1", i, a.req_ready); end
            end else begin
                a.req_valid = 0;
            end
        end
        @(negedge clk);
        checks++; if (a.rsp_valid !== 1'b0) begin failures++; $display("FAIL sweep_drained got=%b want=0", a.rsp_valid); end
    endtask

    task automatic test_forwarding();
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        exp_q.delete(); exp_b.delete(); m_flags = 3'b000;
        @(negedge clk);
        a.flags_valid = 1; a.alu_sel = 4'd1; a.neg_in = 0; a.equal_in = 1; a.carry_in = 0;
        a.req_valid = 1; a.req_cond = 4'd1;
        b.flags_valid = 1; b.alu_sel = 4'd1; b.neg_in = 0; b.equal_in = 1; b.carry_in = 0;
        b.req_valid = 1; b.req_cond = 4'd1;
        m_flags = upd(m_flags, 4'd1, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(model(4'd1, m_flags));
        #1;
        checks++; if (a.req_ready !== 1'b1) begin failures++; $display("FAIL fwd1_ready got=%b want=1", a.req_ready); end
        checks++; if (b.req_ready !== 1'b0) begin failures++; $display("FAIL fwd0_stall_ready got=%b want=0", b.req_ready); end
        @(negedge clk);
        checks++;
        if (a.rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            failures++; $display("FAIL fwd1_rsp_valid got=%b want=1", a.rsp_valid);
        end else begin
            e = exp_q.pop_front();
            $display("rsp fwd1 cond=%0d taken=%b err=%b", e.cond, a.rsp_taken, a.rsp_err);
            if ({a.rsp_taken, a.rsp_err} !== {e.taken, e.err}) begin
                failures++; $display("FAIL fwd1_rsp got=%b%b want=%b%b", a.rsp_taken, a.rsp_err, e.taken, e.err);
            end
        end
        checks++; if (b.rsp_valid !== 1'b0) begin failures++; $display("FAIL fwd0_no_rsp got=%b want=0", b.rsp_valid); end
        a.flags_valid = 0; a.req_valid = 0;
        b.flags_valid = 0;
        exp_b.push_back(model(4'd1, m_flags));
        #1;
        checks++; if (b.req_ready !== 1'b1) begin failures++; $display("FAIL fwd0_ready got=%b want=1", b.req_ready); end
        @(negedge clk);
        b.req_valid = 0;
        checks++;
        if (b.rsp_valid !== 1'b1 || exp_b.size() == 0) begin
            failures++; $display("FAIL fwd0_rsp_valid got=%b want=1", b.rsp_valid);
        end else begin
            e = exp_b.pop_front();
            $display("rsp fwd0 cond=%0d taken=%b err=%b", e.cond, b.rsp_taken, b.rsp_err);
            if ({b.rsp_taken, b.rsp_err} !== {e.taken, e.err}) begin
                failures++; $display("FAIL fwd0_rsp got=%b%b want=%b%b", b.rsp_taken, b.rsp_err, e.taken, e.err);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        a.rsp_ready = 1; a.req_valid = 1; a.req_cond = 4'd1;
        exp_q.push_back(model(4'd1, m_flags));
        @(negedge clk);
        a.rsp_ready = 0; a.req_cond = 4'd12;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (a.rsp_valid !== 1'b1 || exp_q.size() == 0) begin
                failures++; $display("FAIL hold_valid_%0d got=%b want=1", i, a.rsp_valid);
            end else if ({a.rsp_taken, a.rsp_err} !== {exp_q[0].taken, exp_q[0].err}) begin
                failures++; $display("FAIL hold_stable_%0d got=%b%b want=%b%b", i, a.rsp_taken, a.rsp_err, exp_q[0].taken, exp_q[0].err);
            end
            a.flags_valid = 1; a.alu_sel = 4'd0; a.carry_in = 1;
            m_flags = upd(m_flags, 4'd0, 1'b1, 1'b0, 1'b0);
            #1;
            checks++; if (a.req_ready !== 1'b0) begin failures++; $display("FAIL hold_ready_%0d got=%b want=0", i, a.req_ready); end
        end
        @(negedge clk);
        a.flags_valid = 0; a.rsp_ready = 1;
        #1;
        checks++; if (a.req_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b want=1", a.req_ready); end
        checks++;
        if (a.rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            failures++; $display("FAIL release_old_valid got=%b want=1", a.rsp_valid);
        end else begin
            e = exp_q.pop_front();
            $display("rsp held cond=%0d taken=%b err=%b", e.cond, a.rsp_taken, a.rsp_err);
            if ({a.rsp_taken, a.rsp_err} !== {e.taken, e.err}) begin
                failures++; $display("FAIL release_old got=%b%b want=%b%b", a.rsp_taken, a.rsp_err, e.taken, e.err);
            end
        end
        exp_q.push_back(model(4'd12, m_flags));
        @(negedge clk);
        a.req_valid = 0;
        checks++;
        if (a.rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            failures++; $display("FAIL release_new_valid got=%b want=1", a.rsp_valid);
        end else begin
            e = exp_q.pop_front();
            $display("rsp new cond=%0d taken=%b err=%b", e.cond, a.rsp_taken, a.rsp_err);
            if ({a.rsp_taken, a.rsp_err} !== {e.taken, e.err}) begin
                failures++; $display("FAIL release_new got=%b%b want=%b%b", a.rsp_taken, a.rsp_err, e.taken, e.err);
            end
        end
        checks++; if (a.flags_q !== m_flags) begin failures++; $display("FAIL hold_flags got=%b want=%b", a.flags_q, m_flags); end
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk);
        a.rsp_ready = 1; a.req_valid = 1; a.req_cond = 4'd0;
        @(negedge clk);
        a.rsp_ready = 0; a.req_valid = 0;
        checks++; if (a.rsp_valid !== 1'b1) begin failures++; $display("FAIL midhold_full got=%b want=1", a.rsp_valid); end
        reset = 1;
        exp_q.delete();
        m_flags = 3'b000;
        @(negedge clk);
        $display("reset mid-hold rsp_valid=%b flags_q=%b", a.rsp_valid, a.flags_q);
        checks++; if (a.rsp_valid !== 1'b0) begin failures++; $display("FAIL midhold_rsp_valid got=%b want=0", a.rsp_valid); end
        checks++; if (a.flags_q !== m_flags) begin failures++; $display("FAIL midhold_flags got=%b want=%b", a.flags_q, m_flags); end
        reset = 0;
        a.rsp_ready = 1;
        @(negedge clk);
        checks++; if (a.rsp_valid !== 1'b0) begin failures++; $display("FAIL midhold_after got=%b want=0", a.rsp_valid); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_flags = 3'b000;
        reset = 1;
        test_reset();
        test_flags();
        test_sweep();
        test_forwarding();
        test_backpressure();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
